lc3_dmem_access: RTL



---
 rtl/lc3_dmem_access_if.sv | 34 +++
 rtl/lc3_dmem_access.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lc3_dmem_access_if.sv
// Bundles the request, dmem and response signals of the LC3 memory-access stage.
// slave: the stage itself. master: the pipeline and memory that surround it.
interface lc3_dmem_access_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              Data_en;
  logic              Data_rd;
  logic [ADDR_W-1:0] Data_addr;
  logic [DATA_W-1:0] Data_din;
  logic [DATA_W-1:0] Data_dout;
  logic              Data_rdy;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req_valid, req_op, req_addr, req_data, Data_dout, Data_rdy,
    output req_ready, Data_en, Data_rd, Data_addr, Data_din, rsp_valid, rsp_data, rsp_err,
           busy
  );

  modport master (
    output req_valid, req_op, req_addr, req_data, Data_dout, Data_rdy,
    input  req_ready, Data_en, Data_rd, Data_addr, Data_din, rsp_valid, rsp_data, rsp_err,
           busy
  );
endinterface

// File: rtl/lc3_dmem_access.sv
// LC3 memory-access stage: sequences LD/ST/LDI/STI onto the dmem bus, one request at a time.
// Optional abort-on-wait feature enabled by defining DMEM_ACCESS_TIMEOUT_EN.
// Every output is a register loaded from the next-state decode, so the bus view always
// matches the state being entered.
module lc3_dmem_access #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic              clock,
  input logic              reset,
  lc3_dmem_access_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StPtr, StFinal, StResp} state_e;

  // req_op bit meanings
  localparam int unsigned OpStoreBit    = 0;
  localparam int unsigned OpIndirectBit = 1;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              en_q, en_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              in_access;
  logic              abort;

  assign in_access = (state_q == StPtr) || (state_q == StFinal);

`ifdef DMEM_ACCESS_TIMEOUT_EN
  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_q;
  logic [7:0] wait_inc;
  logic       err_q;

  assign wait_inc = wait_q + 8'd1;
  // Abort on the edge where the wait count reaches the limit.
  assign abort    = in_access && !bus_io.Data_rdy && (wait_inc == TimeoutVal);

  // Wait counter: restarts whenever the FSM changes state, counts stalled bus cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_q <= '0;
    end else if (state_d != state_q) begin
      wait_q <= '0;
    end else if (in_access && !bus_io.Data_rdy) begin
      wait_q <= wait_inc;
    end
  end

  // Error flag: an abort always enters RESP, so this is high exactly in that RESP cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= abort;
    end
  end

  assign bus_io.rsp_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort          = 1'b0;
  assign bus_io.rsp_err = 1'b0;
`endif

  // Next-state, latched fields and registered-output decode.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ptr_d      = ptr_q;
    rsp_data_d = '0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.req_valid) begin
          op_d    = bus_io.req_op;
          addr_d  = bus_io.req_addr;
          data_d  = bus_io.req_data;
          state_d = bus_io.req_op[OpIndirectBit] ? StPtr : StFinal;
        end
      end
      StPtr: begin
        if (bus_io.Data_rdy) begin
          ptr_d   = bus_io.Data_dout;
          state_d = StFinal;
        end else if (abort) begin
          state_d = StResp;
        end
      end
      StFinal: begin
        if (bus_io.Data_rdy) begin
          if (!op_q[OpStoreBit]) begin
            rsp_data_d = bus_io.Data_dout;
          end
          state_d = StResp;
        end else if (abort) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d     = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
    en_d        = (state_d == StPtr) || (state_d == StFinal);
    rsp_valid_d = (state_d == StResp);
    rd_d        = 1'b0;
    bus_addr_d  = '0;
    din_d       = '0;
    if (state_d == StPtr) begin
      rd_d       = 1'b1;
      bus_addr_d = addr_d;
    end else if (state_d == StFinal) begin
      rd_d       = !op_d[OpStoreBit];
      bus_addr_d = op_d[OpIndirectBit] ? ptr_d : addr_d;
      din_d      = op_d[OpStoreBit] ? data_d : '0;
    end
  end

  // State, latched request fields and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      ptr_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      en_q        <= 1'b0;
      rd_q        <= 1'b0;
      bus_addr_q  <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ptr_q       <= ptr_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      en_q        <= en_d;
      rd_q        <= rd_d;
      bus_addr_q  <= bus_addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus_io.req_ready = ready_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.Data_en   = en_q;
  assign bus_io.Data_rd   = rd_q;
  assign bus_io.Data_addr = bus_addr_q;
  assign bus_io.Data_din  = din_q;
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_data  = rsp_data_q;

endmodule
